avmm_sdram_write_wrapper: RTL and testbench
===========================================

# avmm_sdram_write_wrapper

Converts a simple write command (start address, beat count, start pulse) plus a valid/ready data stream into Avalon-MM burst writes to the SDRAM controller. It is the write-side counterpart of the SDRAM read wrapper and sits between the NPU result path and the SDRAM write port. Transfers are split into bursts of at most `MAX_BURST` beats. A one-cycle `write_done` pulse is issued after the final beat is accepted by the slave.

## Interface
- `SDRAM_DATA_W`, 128: data width in bits; beat size is `SDRAM_DATA_W/8` bytes.
- `MAX_BURST`, 64: maximum beats per Avalon burst; legal range is 1..1024.
- `clk` in 1: single clock; every signal is synchronous to its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `write_addr` in 32: byte start address, aligned to the beat size; sampled with `write_start`.
- `write_cnt` in 32: total beats to write; sampled with `write_start`.
- `write_start` in 1: command pulse; honoured only in IDLE.
- `write_data` in `SDRAM_DATA_W`: stream data.
- `write_valid` in 1: stream data valid.
- `write_ready` out 1: stream beat accepted when `write_valid && write_ready`.
- `write_busy` out 1: high in any state other than IDLE.
- `write_done` out 1: one-cycle pulse at command completion.
- `address` out 32: Avalon byte address of the current burst.
- `burstcount` out 11: beats in the current burst.
- `writedata` out `SDRAM_DATA_W`: Avalon write data.
- `byteenable` out `SDRAM_DATA_W/8`: constant all-ones.
- `write` out 1: Avalon write request.
- `waitrequest` in 1: Avalon slave stall.

## Operation
- The FSM has four states: IDLE, SETUP, BURST, DONE.
- IDLE, with `write_start`=1:
  - Latch `write_addr` into the next-address register and `write_cnt` into the remaining counter (32b).
  - If `write_cnt`=0, go to DONE; otherwise go to SETUP.
- SETUP:
  - `burst_len = min(remaining, MAX_BURST)`.
  - Drive `address` and `burstcount` from the registers; hold both constant for the whole burst.
  - Clear the beat counter, then go to BURST.
- BURST, data path:
  - A single output register holds one beat (`writedata`, `write`).
  - `write_ready = (beats_loaded < burst_len) && (!write || !waitrequest)`.
  - A stream handshake loads the register and sets `write`=1.
  - Slave acceptance (`write && !waitrequest`) with no new load clears `write`.
- BURST, accounting:
  - On each slave acceptance, increment the beat counter and decrement `remaining`.
  - On acceptance of beat `burst_len`, set the next address to `address + burst_len*SDRAM_DATA_W/8` (32b, wraps modulo 2^32).
  - Then go to DONE if `remaining` is 0, else to SETUP.
- DONE: `write_done`=1 for exactly one cycle, then go to IDLE.
- `write_start` outside IDLE is ignored. `write_cnt` and `write_addr` are not re-sampled mid-command.
- No address-boundary splitting is performed; only `MAX_BURST` limits burst size.
- `write_valid` low mid-burst: `write` drops after the pending beat is accepted. `address`/`burstcount` stay stable and the burst resumes when data arrives.
- `waitrequest` high: `write`, `writedata`, `address` and `burstcount` hold unchanged, and `write_ready` is 0 while a beat is pending.
- Reset, including mid-burst: go to IDLE immediately and abandon the in-flight burst.

## Timing
- Reset values:
  - `write`, `write_ready`, `write_busy` and `write_done` are 0.
  - `address`, `burstcount` and `writedata` are 0.
  - `byteenable` is all-ones.
- All outputs are registered except `write_ready`, which is combinational from state, counters, `write` and `waitrequest`.
- `write_start` sampled at edge k means SETUP at k+1 and BURST at k+2, where `write_ready` is first high.
- Stream beat accepted at edge n puts `write`=1 with that data in cycle n+1.
- Throughput: with `write_valid` and `!waitrequest` held high, one beat per cycle within a burst.
- There is one SETUP bubble cycle between bursts.
- Last beat accepted by the slave at edge m puts `write_done`=1 in cycle m+1, and `write_busy`=0 from m+2.
- With `write_cnt`=0, `write_done` is high the cycle after start is sampled, and no `write` is issued.

## Test plan
1. `write_addr`=0x2000_0000, `write_cnt`=1, data 0xA5.. → one burst: `address`=0x2000_0000, `burstcount`=1, one `write` beat; `write_done` pulses one cycle after acceptance; the BFM memory holds the beat.
2. `write_cnt`=150, `MAX_BURST`=64, incrementing data → three bursts:
   - `burstcount` 64 at 0x2000_0000;
   - `burstcount` 64 at 0x2000_0400;
   - `burstcount` 22 at 0x2000_0800.
   - All 150 beats match in the BFM memory, and there is exactly one `write_done`.
3. `write_cnt`=20 with `waitrequest` forced high for 5 cycles at beat 7 → `write`/`writedata`/`address`/`burstcount` stable during the stall, `write_ready`=0, no beat lost or duplicated.
4. `write_cnt`=16 with `write_valid` toggled every other cycle → `write` deasserts between beats, `burstcount` stays 16 throughout, and the data is correct.
5. `write_cnt`=0 → `write_done` high the cycle after `write_start`, `write` never asserted, `write_busy` high for exactly one cycle.
6. `rst_n` asserted after 10 of 64 beats → `write`, `write_busy` and `write_ready` drop to 0 asynchronously. A new command with `write_cnt`=4 after reset completes correctly, and `write_start` pulses while busy are ignored.

Source files
------------

// File: rtl/avmm_sdram_write_wrapper.sv
// avmm_sdram_write_wrapper: splits a start/count write command plus a valid/ready stream into Avalon-MM burst writes.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   write_addr, write_cnt       byte start address and beat count, sampled with write_start in IDLE
//   write_start                 command pulse
//   write_data/valid/ready      input beat stream
//   write_busy, write_done      command status (done is a one-cycle pulse)
//   address, burstcount         Avalon burst address/length, held for the whole burst
//   writedata, byteenable       Avalon write data, byteenable tied all-ones
//   write, waitrequest          Avalon write request and slave stall
module avmm_sdram_write_wrapper #(
  parameter int SDRAM_DATA_W = 128,
  parameter int MAX_BURST = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               write_addr,
  input  logic [31:0]               write_cnt,
  input  logic                      write_start,
  input  logic [SDRAM_DATA_W-1:0]   write_data,
  input  logic                      write_valid,
  output logic                      write_ready,
  output logic                      write_busy,
  output logic                      write_done,
  output logic [31:0]               address,
  output logic [10:0]               burstcount,
  output logic [SDRAM_DATA_W-1:0]   writedata,
  output logic [SDRAM_DATA_W/8-1:0] byteenable,
  output logic                      write,
  input  logic                      waitrequest
);
  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;
  localparam logic [31:0] BYTES = 32'(SDRAM_DATA_W / 8);
  localparam logic [31:0] MAXB = 32'(MAX_BURST);
  state_t state, state_n;
  logic [31:0] next_addr, next_addr_n, remaining, remaining_n, address_n;
  logic [10:0] burstcount_n, beats_acc, beats_acc_n, beats_loaded, beats_loaded_n;
  logic [SDRAM_DATA_W-1:0] writedata_n;
  logic write_n, load, accept;
  assign byteenable = '1;
  // A new beat may enter the single output register only if the burst still needs
  // beats and the register is empty or being drained this cycle.
  assign write_ready = (state == BURST) && (beats_loaded < burstcount) && (!write || !waitrequest);
  assign load = write_valid && write_ready;
  assign accept = (state == BURST) && write && !waitrequest;
  always_comb begin
    state_n = state;
    next_addr_n = next_addr;
    remaining_n = remaining;
    address_n = address;
    burstcount_n = burstcount;
    beats_acc_n = beats_acc;
    beats_loaded_n = beats_loaded;
    writedata_n = writedata;
    write_n = write;
    case (state)
      IDLE: if (write_start) begin
        next_addr_n = write_addr;
        remaining_n = write_cnt;
        state_n = (write_cnt == 32'd0) ? DONE : SETUP;
      end
      SETUP: begin
        address_n = next_addr;
        // MAX_BURST is at most 1024, so the truncation to 11 bits is lossless
        burstcount_n = (remaining < MAXB) ? remaining[10:0] : MAXB[10:0];
        beats_acc_n = '0;
        beats_loaded_n = '0;
        state_n = BURST;
      end
      BURST: begin
        if (load) begin
          writedata_n = write_data;
          write_n = 1'b1;
          beats_loaded_n = beats_loaded + 11'd1;
        end else if (accept) write_n = 1'b0;
        if (accept) begin
          beats_acc_n = beats_acc + 11'd1;
          remaining_n = remaining - 32'd1;
          if (beats_acc_n == burstcount) begin
            next_addr_n = address + 32'(burstcount) * BYTES;
            state_n = (remaining_n == 32'd0) ? DONE : SETUP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      next_addr <= '0;
      remaining <= '0;
      address <= '0;
      burstcount <= '0;
      beats_acc <= '0;
      beats_loaded <= '0;
      writedata <= '0;
      write <= 1'b0;
      write_busy <= 1'b0;
      write_done <= 1'b0;
    end else begin
      state <= state_n;
      next_addr <= next_addr_n;
      remaining <= remaining_n;
      address <= address_n;
      burstcount <= burstcount_n;
      beats_acc <= beats_acc_n;
      beats_loaded <= beats_loaded_n;
      writedata <= writedata_n;
      write <= write_n;
      write_busy <= state_n != IDLE;
      write_done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_avmm_sdram_write_wrapper.sv
// tb_avmm_sdram_write_wrapper: directed scoreboard bench for the Avalon-MM burst write wrapper.
module tb_avmm_sdram_write_wrapper;
  typedef struct {
    logic [31:0] a;
    logic [10:0] c;
  } burst_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] write_addr = '0, write_cnt = '0;
  logic write_start = 1'b0, write_valid = 1'b0, waitrequest = 1'b0;
  logic [127:0] write_data = '0;
  logic write_ready, write_busy, write_done, write;
  logic [31:0] address;
  logic [10:0] burstcount;
  logic [127:0] writedata;
  logic [15:0] byteenable;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, write_hi = 0, done_cnt = 0, done_cyc = 0, last_acc = 0, tot_acc = 0;
  int bidx = 0, stall_seen = 0, base = 0, d0 = 0, w0 = 0;
  logic [127:0] exp_q[$];
  burst_t burst_q[$];
  logic [127:0] mem[logic [31:0]];
  avmm_sdram_write_wrapper #(.SDRAM_DATA_W(128), .MAX_BURST(64)) dut (
    .clk(clk), .rst_n(rst_n), .write_addr(write_addr), .write_cnt(write_cnt),
    .write_start(write_start), .write_data(write_data), .write_valid(write_valid),
    .write_ready(write_ready), .write_busy(write_busy), .write_done(write_done),
    .address(address), .burstcount(burstcount), .writedata(writedata),
    .byteenable(byteenable), .write(write), .waitrequest(waitrequest)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cmd(input logic [31:0] a, input logic [31:0] n);
    logic [31:0] rem = n, ad = a, c;
    while (rem > 0) begin
      c = (rem < 64) ? rem : 32'd64;
      burst_q.push_back('{a: ad, c: c[10:0]});
      ad += c * 16;
      rem -= c;
    end
    base = tot_acc;
    d0 = done_cnt;
    w0 = write_hi;
    @(posedge clk); #1;
    write_addr = a;
    write_cnt = n;
    write_start = 1'b1;
    @(posedge clk); #1;
    write_start = 1'b0;
  endtask
  task automatic stream(input int n, input logic [127:0] b, input bit toggle);
    int i = 0, g = 0;
    bit hs, ph = 1'b1;
    while (i < n && g < 3000) begin
      write_valid = toggle ? ph : 1'b1;
      write_data = b + 128'(i);
      @(negedge clk);
      hs = write_valid && write_ready;
      if (hs) exp_q.push_back(write_data);
      @(posedge clk); #1;
      if (hs) i++;
      ph = !ph;
      g++;
    end
    write_valid = 1'b0;
    chk("stream_beats", 128'(i), 128'(n));
  endtask
  task automatic finish_cmd(input string tag);
    int g = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
    chk({tag, "_data_left"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_bursts_left"}, 128'(burst_q.size()), 128'd0);
    chk({tag, "_busy_after"}, 128'(write_busy), 128'd0);
  endtask
  task automatic stall_ctl();
    int g = 0;
    while (tot_acc - base < 7 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    waitrequest = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    waitrequest = 1'b0;
  endtask
  task automatic pulse_ignored();
    repeat (2) begin
      @(posedge clk); #1;
      write_addr = 32'h7000_0000;
      write_cnt = 32'd99;
      write_start = 1'b1;
      @(posedge clk); #1;
      write_start = 1'b0;
    end
  endtask
  initial begin
    int errs, g;
    burst_t eb;
    logic [127:0] ed;
    bit p_v = 1'b0, p_write = 1'b0, p_wait = 1'b0;
    logic [127:0] p_wd = '0;
    logic [31:0] p_addr = '0, b_addr = '0;
    logic [10:0] p_bc = '0, b_cnt = '0;
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          bidx = 0;
          p_v = 1'b0;
        end else begin
          cyc++;
          if (write) write_hi++;
          if (write_done) begin
            done_cnt++;
            done_cyc = cyc;
          end
          if (p_v && p_write && p_wait) begin
            chk("stall_write", 128'(write), 128'd1);
            chk("stall_writedata", writedata, p_wd);
            chk("stall_address", 128'(address), 128'(p_addr));
            chk("stall_burstcount", 128'(burstcount), 128'(p_bc));
          end
          if (write && waitrequest) begin
            stall_seen++;
            chk("stall_ready", 128'(write_ready), 128'd0);
          end
          if (write && !waitrequest) begin
            if (bidx == 0) begin
              chk("burst_expected", 128'(burst_q.size() != 0), 128'd1);
              if (burst_q.size() != 0) begin
                eb = burst_q.pop_front();
                chk("burst_address", 128'(address), 128'(eb.a));
                chk("burst_count", 128'(burstcount), 128'(eb.c));
              end
              b_addr = address;
              b_cnt = burstcount;
            end else begin
              chk("beat_address_stable", 128'(address), 128'(b_addr));
              chk("beat_count_stable", 128'(burstcount), 128'(b_cnt));
            end
            chk("beat_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
              ed = exp_q.pop_front();
              chk("beat_data", writedata, ed);
            end
            mem[b_addr + 32'(bidx) * 16] = writedata;
            bidx = (11'(bidx + 1) == b_cnt) ? 0 : bidx + 1;
            tot_acc++;
            last_acc = cyc;
          end
          p_v = 1'b1;
          p_write = write;
          p_wait = waitrequest;
          p_wd = writedata;
          p_addr = address;
          p_bc = burstcount;
        end
      end
    join_none
    #12;
    chk("rst_write", 128'(write), 128'd0);
    chk("rst_ready", 128'(write_ready), 128'd0);
    chk("rst_busy", 128'(write_busy), 128'd0);
    chk("rst_done", 128'(write_done), 128'd0);
    chk("rst_address", 128'(address), 128'd0);
    chk("rst_burstcount", 128'(burstcount), 128'd0);
    chk("rst_writedata", writedata, 128'd0);
    chk("rst_byteenable", 128'(byteenable), 128'hffff);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // single beat
    cmd(32'h2000_0000, 32'd1);
    stream(1, {16{8'hA5}}, 1'b0);
    finish_cmd("t1");
    chk("t1_done_latency", 128'(done_cyc - last_acc), 128'd1);
    chk("t1_mem", mem[32'h2000_0000], {16{8'hA5}});
    // three bursts 64/64/22
    cmd(32'h2000_0000, 32'd150);
    stream(150, 128'h1000, 1'b0);
    finish_cmd("t2");
    errs = 0;
    for (int i = 0; i < 150; i++)
      if (mem[32'h2000_0000 + 32'(i) * 16] !== 128'h1000 + 128'(i)) errs++;
    chk("t2_mem", 128'(errs), 128'd0);
    // slave stall for five cycles at beat 7
    stall_seen = 0;
    cmd(32'h2100_0000, 32'd20);
    fork
      stream(20, 128'h5000, 1'b0);
      stall_ctl();
    join
    finish_cmd("t3");
    chk("t3_stall_cycles", 128'(stall_seen), 128'd5);
    // stream valid toggling
    cmd(32'h2200_0000, 32'd16);
    stream(16, 128'h9000, 1'b1);
    finish_cmd("t4");
    chk("t4_write_cycles", 128'(write_hi - w0), 128'd16);
    // zero-length command
    cmd(32'h2300_0000, 32'd0);
    chk("t5_done", 128'(write_done), 128'd1);
    chk("t5_busy", 128'(write_busy), 128'd1);
    @(posedge clk); #1;
    chk("t5_done_off", 128'(write_done), 128'd0);
    chk("t5_busy_off", 128'(write_busy), 128'd0);
    finish_cmd("t5");
    chk("t5_no_write", 128'(write_hi - w0), 128'd0);
    // reset after 10 of 64 beats
    cmd(32'h2400_0000, 32'd64);
    stream(11, 128'hC000, 1'b0);
    g = 0;
    while (tot_acc - base < 10 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    chk("t6_ten_beats", 128'(tot_acc - base), 128'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_write", 128'(write), 128'd0);
    chk("t6_rst_busy", 128'(write_busy), 128'd0);
    chk("t6_rst_ready", 128'(write_ready), 128'd0);
    exp_q.delete();
    burst_q.delete();
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmd(32'h2500_0000, 32'd4);
    fork
      stream(4, 128'hE000, 1'b0);
      pulse_ignored();
    join
    finish_cmd("t6");
    chk("t6_mem_last", mem[32'h2500_0030], 128'hE003);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
